// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that puts up to NUM_CDB functional-unit results per cycle onto registered CDB slots.
// Optional mispredict flush input is enabled by defining CDB_ARB_FLUSH_EN.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef CDB_ARB_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    input  logic [NUM_REQ*5-1:0]      req_rd,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    output logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic [NUM_CDB*5-1:0]      cdb_rd,
    output logic [PTR_W-1:0]          rr_ptr_o
);

    logic                             w_flush;
    logic [PTR_W-1:0]                 r_ptr;
    logic [PTR_W-1:0]                 w_next_ptr;
    logic [NUM_REQ-1:0]               w_ready;
    logic [NUM_CDB-1:0]               w_slot_vld;
    logic [NUM_CDB-1:0][PTR_W-1:0]    w_slot_src;
    logic [NUM_CDB-1:0][TAG_W-1:0]    w_tag;
    logic [NUM_CDB-1:0][DATA_W-1:0]   w_value;
    logic [NUM_CDB-1:0][4:0]          w_rd;

    logic [NUM_CDB-1:0]               r_cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]         r_cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]        r_cdb_value;
    logic [NUM_CDB*5-1:0]             r_cdb_rd;

`ifdef CDB_ARB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Scan from r_ptr; the k-th valid requester found takes slot k.
    always_comb begin
        int               cnt;
        int               last;
        int               idx;
        logic [PTR_W-1:0] idx_p;
        cnt        = 0;
        last       = 0;
        idx        = 0;
        idx_p      = '0;
        w_ready    = '0;
        w_slot_vld = '0;
        w_slot_src = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx   = (int'(r_ptr) + k) % NUM_REQ;
            idx_p = PTR_W'(idx);
            if (!rst && !w_flush && req_valid[idx_p] && cnt < NUM_CDB) begin
                w_ready[idx_p] = 1'b1;
                for (int j = 0; j < NUM_CDB; j++) begin
                    if (j == cnt) begin
                        w_slot_vld[j] = 1'b1;
                        w_slot_src[j] = idx_p;
                    end
                end
                cnt  = cnt + 1;
                last = idx;
            end
        end
        w_next_ptr = (cnt != 0) ? PTR_W'((last + 1) % NUM_REQ) : r_ptr;
    end

    always_comb begin
        w_tag   = '0;
        w_value = '0;
        w_rd    = '0;
        for (int j = 0; j < NUM_CDB; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_slot_src[j] == PTR_W'(i)) begin
                    w_tag[j]   = req_tag[i*TAG_W +: TAG_W];
                    w_value[j] = req_value[i*DATA_W +: DATA_W];
                    w_rd[j]    = req_rd[i*5 +: 5];
                end
            end
        end
    end

    // Payload of unused slots is don't-care, so it loads unconditionally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_cdb_valid <= '0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
            r_cdb_rd    <= '0;
        end else begin
            r_ptr       <= w_next_ptr;
            r_cdb_valid <= w_slot_vld;
            r_cdb_tag   <= w_tag;
            r_cdb_value <= w_value;
            r_cdb_rd    <= w_rd;
        end
    end

    assign req_ready = w_ready;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_value = r_cdb_value;
    assign cdb_rd    = r_cdb_rd;
    assign rr_ptr_o  = r_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_REQ=4, NUM_CDB=2).
// Inputs change and outputs are sampled around the falling edge; the DUT acts on the rising edge.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic [NUM_REQ*5-1:0]      req_rd;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_value;
    logic [NUM_CDB*5-1:0]      cdb_rd;
    logic [1:0]                rr_ptr_o;

    int n_cmp;
    int n_bad;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CDB_ARB_FLUSH_EN
        .flush     (flush),
`endif
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_value (req_value),
        .req_rd    (req_rd),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_rd    (cdb_rd),
        .rr_ptr_o  (rr_ptr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v,
                           input logic [4:0] d);
        req_tag[i*TAG_W +: TAG_W]    = t;
        req_value[i*DATA_W +: DATA_W] = v;
        req_rd[i*5 +: 5]             = d;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b00) begin
            n_bad++; $display("FAIL reset_cdb_valid: got %b want 00", cdb_valid);
        end
        n_cmp++;
        if (rr_ptr_o !== 2'd0) begin
            n_bad++; $display("FAIL reset_ptr: got %0d want 0", rr_ptr_o);
        end
        req_valid = 4'b0000;
        rst = 1'b0;
        next_cyc();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, TAG_W'(i + 1), 32'h100 + i, 5'(i + 1));
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0011) begin
            n_bad++; $display("FAIL sat_c0_ready: got %b want 0011", req_ready);
        end
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b11 || cdb_tag[3:0] !== 4'd1 || cdb_tag[7:4] !== 4'd2) begin
            n_bad++; $display("FAIL sat_c1_cdb: got v=%b tags=%h want v=11 tags=21", cdb_valid, cdb_tag);
        end
        n_cmp++;
        if (req_ready !== 4'b1100 || rr_ptr_o !== 2'd2) begin
            n_bad++; $display("FAIL sat_c1_ready_ptr: got %b/%0d want 1100/2", req_ready, rr_ptr_o);
        end
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b11 || cdb_tag[3:0] !== 4'd3 || cdb_tag[7:4] !== 4'd4 ||
            cdb_value[31:0] !== 32'h102 || cdb_rd[9:5] !== 5'd4) begin
            n_bad++; $display("FAIL sat_c2_cdb: got v=%b tags=%h val0=%h rd1=%0d want v=11 tags=43 val0=102 rd1=4",
                              cdb_valid, cdb_tag, cdb_value[31:0], cdb_rd[9:5]);
        end
        n_cmp++;
        if (rr_ptr_o !== 2'd0) begin
            n_bad++; $display("FAIL sat_c2_ptr: got %0d want 0", rr_ptr_o);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_empty();
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL empty_ready: got %b want 0000", req_ready);
        end
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b00 || rr_ptr_o !== 2'd0) begin
            n_bad++; $display("FAIL empty_cdb_ptr: got %b/%0d want 00/0", cdb_valid, rr_ptr_o);
        end
    endtask

    task automatic test_single();
        set_req(3, 4'd5, 32'hDEADBEEF, 5'd7);
        req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_bad++; $display("FAIL single_ready: got %b want 1000", req_ready);
        end
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b01 || cdb_tag[3:0] !== 4'd5 || cdb_value[31:0] !== 32'hDEADBEEF ||
            cdb_rd[4:0] !== 5'd7) begin
            n_bad++; $display("FAIL single_cdb: got v=%b tag=%0d val=%h rd=%0d want v=01 tag=5 val=deadbeef rd=7",
                              cdb_valid, cdb_tag[3:0], cdb_value[31:0], cdb_rd[4:0]);
        end
        n_cmp++;
        if (rr_ptr_o !== 2'd0) begin
            n_bad++; $display("FAIL single_wrap_ptr: got %0d want 0", rr_ptr_o);
        end
        req_valid = 4'b0000;
        next_cyc();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy [4];
        logic [1:0] exp_ptr [4];
        exp_rdy = '{4'b0101, 4'b1001, 4'b0110, 4'b1001};
        exp_ptr = '{2'd0, 2'd3, 2'd1, 2'd3};
        for (int i = 0; i < NUM_REQ; i++) set_req(i, TAG_W'(i + 1), 32'h200 + i, 5'd0);
        req_valid = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) req_valid = 4'b1111;
            #1;
            n_cmp++;
            if (req_ready !== exp_rdy[c] || rr_ptr_o !== exp_ptr[c]) begin
                n_bad++; $display("FAIL fair_c%0d: got rdy=%b ptr=%0d want rdy=%b ptr=%0d",
                                  c, req_ready, rr_ptr_o, exp_rdy[c], exp_ptr[c]);
            end
            next_cyc();
            if (c == 1) begin
                n_cmp++;
                if (cdb_valid !== 2'b11 || cdb_tag[3:0] !== 4'd4 || cdb_tag[7:4] !== 4'd1) begin
                    n_bad++; $display("FAIL fair_c1_cdb: got v=%b tags=%h want v=11 tags=14", cdb_valid, cdb_tag);
                end
            end
        end
        req_valid = 4'b0000;
        n_cmp++;
        if (rr_ptr_o !== 2'd1) begin
            n_bad++; $display("FAIL fair_end_ptr: got %0d want 1", rr_ptr_o);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1111;
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b11) begin
            n_bad++; $display("FAIL mid_pre_valid: got %b want 11", cdb_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready);
        end
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b00 || rr_ptr_o !== 2'd0) begin
            n_bad++; $display("FAIL mid_rst_after: got %b/%0d want 00/0", cdb_valid, rr_ptr_o);
        end
        rst = 1'b0;
        req_valid = 4'b0000;
        next_cyc();
    endtask

    task automatic test_rd_zero();
        set_req(0, 4'd9, 32'h0000_0000, 5'd0);
        req_valid = 4'b0001;
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b01 || cdb_tag[3:0] !== 4'd9 || cdb_rd[4:0] !== 5'd0 || rr_ptr_o !== 2'd1) begin
            n_bad++; $display("FAIL rd0_cdb: got v=%b tag=%0d rd=%0d ptr=%0d want v=01 tag=9 rd=0 ptr=1",
                              cdb_valid, cdb_tag[3:0], cdb_rd[4:0], rr_ptr_o);
        end
        req_valid = 4'b0000;
        next_cyc();
    endtask

`ifdef CDB_ARB_FLUSH_EN
    task automatic test_flush();
        set_req(1, 4'd6, 32'h11, 5'd1);
        set_req(2, 4'd7, 32'h22, 5'd2);
        req_valid = 4'b0110;
        flush = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL flush_ready: got %b want 0000", req_ready);
        end
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b00 || rr_ptr_o !== 2'd1) begin
            n_bad++; $display("FAIL flush_cdb_ptr: got %b/%0d want 00/1", cdb_valid, rr_ptr_o);
        end
        flush = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0110) begin
            n_bad++; $display("FAIL flush_release_ready: got %b want 0110", req_ready);
        end
        next_cyc();
        n_cmp++;
        if (cdb_valid !== 2'b11 || cdb_tag[3:0] !== 4'd6 || cdb_tag[7:4] !== 4'd7) begin
            n_bad++; $display("FAIL flush_release_cdb: got v=%b tags=%h want v=11 tags=76", cdb_valid, cdb_tag);
        end
        req_valid = 4'b0000;
        next_cyc();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0;
        req_tag = '0;
        req_value = '0;
        req_rd = '0;
        @(negedge clk);
        test_reset();
        test_saturation();
        test_empty();
        test_single();
        test_fairness();
        test_reset_mid();
        test_rd_zero();
`ifdef CDB_ARB_FLUSH_EN
        test_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Schedules functional-unit results onto the shared common data buses (CDBs) of the out-of-order core.
- Requesters are the ALU, MUL, CMP and LD/ST reservation-station/execute pipes; they compete for NUM_CDB broadcast slots.
- Grants are round-robin with a valid/ready handshake.
- Granted results are registered onto the CDB outputs, which feed rename, the reservation stations, the ROB and the regfile.

Parameters:
NUM_REQ, 4, number of requesting functional units (>=2)
NUM_CDB, 2, number of CDB broadcast slots (1..NUM_REQ)
TAG_W, 4, ROB tag width
DATA_W, 32, result value width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  requester i has a result pending
req_tag  input  NUM_REQ*TAG_W  ROB tag per requester, packed, requester i at [i*TAG_W +: TAG_W]
req_value  input  NUM_REQ*DATA_W  result value per requester, packed likewise
req_rd  input  NUM_REQ*5  architectural destination per requester, packed likewise
req_ready  output  NUM_REQ  grant to requester i this cycle (combinational)
cdb_valid  output  NUM_CDB  slot j carries a broadcast
cdb_tag  output  NUM_CDB*TAG_W  broadcast tag per slot
cdb_value  output  NUM_CDB*DATA_W  broadcast value per slot
cdb_rd  output  NUM_CDB*5  broadcast destination per slot
rr_ptr_o  output  $clog2(NUM_REQ)  current round-robin start index (debug/verification)

Behaviour:
- Reset: clk, rst synchronous, active-high.
  - While rst is high: req_ready=0, and on the reset edge cdb_valid/tag/value/rd load 0 and rr_ptr loads 0.
  - Reset mid-operation drops all in-flight grants; requesters keep their results.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Once valid is asserted, the requester holds valid, tag, value and rd stable until ready.
  - req_ready[i] never asserts without req_valid[i].
- Grant selection (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - Grant the first min(NUM_CDB, popcount(req_valid)) valid requesters.
  - The k-th grant in scan order takes CDB slot k.
- Latency: exactly 1 cycle.
  - Data handshaken in cycle N appears on cdb_* in cycle N+1.
  - cdb_valid[j]=0 for unused slots; unused slot tag/value/rd are don't-care.
  - Outputs are fully registered, with no combinational path from req_* to cdb_*.
- Pointer update:
  - If at least one grant occurs, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - With no grants, rr_ptr holds.
  - Wrap from NUM_REQ-1 to 0 is required.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/NUM_CDB) cycles.
- rd=0 results are broadcast like any other; the ROB needs the completion.
- Only one requester may present a given tag per cycle; the arbiter does not check for duplicate tags.
- Empty cycle (no valid): all req_ready=0; next cycle all cdb_valid=0.

Optional Feature:
CDB_ARB_FLUSH_EN
- With the macro defined: extra input port `flush` (1 bit), a synchronous mispredict flush.
  - While flush=1: all req_ready=0, cdb_valid loads 0 on the next edge, rr_ptr holds.
  - Results already registered on the CDB in the flush cycle are still visible that cycle.
- Without the macro: the port is absent and the arbiter never suppresses grants.

Test Plan:
- Reset: rst=1 with req_valid=4'b1111 -> req_ready=0; after the edge cdb_valid=2'b00, rr_ptr_o=0.
- Saturation:
  - Stimulus: rr_ptr=0, req_valid=4'b1111 held, tags 1,2,3,4.
  - Cycle 0: req_ready=4'b0011; cycle 1: cdb_valid=2'b11, cdb_tag slot0=1 / slot1=2, req_ready=4'b1100, rr_ptr_o=2.
  - Cycle 2: cdb tags 3,4, rr_ptr_o=0.
- Single requester: only req 3 valid, tag 5, value 0xDEADBEEF, rd 7 -> req_ready=4'b1000 same cycle; next cycle cdb_valid=2'b01, slot0 tag 5 / value 0xDEADBEEF / rd 7; rr_ptr_o=0 (wrap).
- Fairness: reqs 0,2,3 continuously valid with rr_ptr=0, req 1 raised at cycle 1 -> every requester granted within 2 cycles of asserting valid; no requester granted twice before a waiting one.
- Empty and reset mid-stream:
  - req_valid=0 for 1 cycle -> req_ready=0, cdb_valid=0 next cycle, rr_ptr_o unchanged.
  - rst pulsed while cdb_valid=2'b11 -> cdb_valid=0 and rr_ptr_o=0 after the edge.
- Flush (CDB_ARB_FLUSH_EN): flush=1 with req_valid=4'b0110 -> req_ready=0, next cycle cdb_valid=0; flush=0 the following cycle -> req 1 and req 2 granted and broadcast one cycle later.
